// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types: load addressing modes, writeback source select
// and datapath widths.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      AC_LB  = 3'b000,
      AC_LH  = 3'b001,
      AC_LW  = 3'b010,
      AC_LBU = 3'b100,
      AC_LHU = 3'b101
   } addr_ctrl_e;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10
   } result_src_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB boundary bundle: M-stage instruction fields and stall/flush controls
// flowing in, W-stage register-file port and counters flowing out.
interface mem_wb_stage_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
);
   logic                  cache_stall;
   logic                  flush_w;
   logic                  valid_m;
   logic                  reg_write_m;
   logic [1:0]            result_src_m;
   logic [2:0]            addressing_control_m;
   logic [REG_ADDR_W-1:0] rd_m;
   logic [XLEN-1:0]       alu_result_m;
   logic [XLEN-1:0]       read_data_m;
   logic [XLEN-1:0]       pc_plus4_m;

   logic                  valid_w;
   logic                  reg_write_w;
   logic [REG_ADDR_W-1:0] rd_w;
   logic [XLEN-1:0]       result_w;
   logic [CNT_W-1:0]      retire_count;
   logic [CNT_W-1:0]      stall_count;

   modport master (
      output cache_stall, flush_w, valid_m, reg_write_m, result_src_m,
             addressing_control_m, rd_m, alu_result_m, read_data_m, pc_plus4_m,
      input  valid_w, reg_write_w, rd_w, result_w, retire_count, stall_count
   );

   modport slave (
      input  cache_stall, flush_w, valid_m, reg_write_m, result_src_m,
             addressing_control_m, rd_m, alu_result_m, read_data_m, pc_plus4_m,
      output valid_w, reg_write_w, rd_w, result_w, retire_count, stall_count
   );
endinterface

// File: rtl/load_extend.sv
// Load data alignment: picks the addressed byte/halfword out of the raw memory
// word and sign- or zero-extends it to XLEN.
module load_extend #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      offset,
   input  logic [2:0]      addr_ctrl,
   output logic [XLEN-1:0] ext
);
   import riscv_pkg::*;

   logic [7:0]  lanes [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lanes[gi] = word[8*gi +: 8];
      end
   endgenerate

   // Odd halfword offsets fall back to the aligned half; no misalignment trap.
   assign byte_sel = lanes[offset];
   assign half_sel = offset[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};

   always_comb begin
      case (addr_ctrl)
         AC_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         AC_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
         AC_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
         AC_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
         default: ext = word;
      endcase
   end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback result select, stall hold, flush
// bubble insertion, and retire / cache-stall cycle counters.
module mem_wb_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   mem_wb_stage_if.slave  bus
);
   import riscv_pkg::*;

   logic [XLEN-1:0]       load_data;
   logic [XLEN-1:0]       result_m;

   logic                  valid_reg, valid_next;
   logic                  reg_write_reg, reg_write_next;
   logic [REG_ADDR_W-1:0] rd_reg, rd_next;
   logic [XLEN-1:0]       result_reg, result_next;
   logic [CNT_W-1:0]      retire_reg, retire_next;
   logic [CNT_W-1:0]      stall_reg, stall_next;

   load_extend #(.XLEN(XLEN)) u_load_extend (
      .word      (bus.read_data_m),
      .offset    (bus.alu_result_m[1:0]),
      .addr_ctrl (bus.addressing_control_m),
      .ext       (load_data)
   );

   // Encoding 11 is unused and falls through to the ALU result.
   always_comb begin
      case (result_src_e'(bus.result_src_m))
         RES_LOAD: result_m = load_data;
         RES_PC4:  result_m = bus.pc_plus4_m;
         default:  result_m = bus.alu_result_m;
      endcase
   end

   // A stall freezes the slot outright, so a flush arriving during a stall is
   // dropped; the hazard unit repeats it once the memory stage completes.
   always_comb begin
      valid_next     = valid_reg;
      reg_write_next = reg_write_reg;
      rd_next        = rd_reg;
      result_next    = result_reg;
      retire_next    = retire_reg;
      stall_next     = stall_reg;
      if (bus.cache_stall) begin
         stall_next = stall_reg + CNT_W'(1);
      end else if (bus.flush_w) begin
         valid_next     = 1'b0;
         reg_write_next = 1'b0;
         rd_next        = '0;
         result_next    = '0;
      end else begin
         valid_next     = bus.valid_m;
         reg_write_next = bus.valid_m & bus.reg_write_m & (bus.rd_m != '0);
         rd_next        = bus.rd_m;
         result_next    = result_m;
         if (bus.valid_m) begin
            retire_next = retire_reg + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg     <= 1'b0;
         reg_write_reg <= 1'b0;
         rd_reg        <= '0;
         result_reg    <= '0;
         retire_reg    <= '0;
         stall_reg     <= '0;
      end else begin
         valid_reg     <= valid_next;
         reg_write_reg <= reg_write_next;
         rd_reg        <= rd_next;
         result_reg    <= result_next;
         retire_reg    <= retire_next;
         stall_reg     <= stall_next;
      end
   end

   assign bus.valid_w      = valid_reg;
   assign bus.reg_write_w  = reg_write_reg;
   assign bus.rd_w         = rd_reg;
   assign bus.result_w     = result_reg;
   assign bus.retire_count = retire_reg;
   assign bus.stall_count  = stall_reg;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed load/result/stall/flush/reset scenarios plus
// randomized traffic scored against a behavioural writeback model.
module tb_mem_wb_stage;

   logic clk;
   logic rst_n;
   int   checks;
   int   passes;

   mem_wb_stage_if #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) bus ();
   mem_wb_stage_if #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4))  bus4 ();

   mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state for the 32-bit-counter instance.
   logic        m_valid, m_rw;
   logic [4:0]  m_rd;
   logic [31:0] m_res, m_retire, m_stall;

   function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] off, logic [2:0] ac);
      logic [31:0] b, h;
      b = (w >> (8 * off)) & 32'h0000_00FF;
      h = (w >> (16 * off[1])) & 32'h0000_FFFF;
      case (ac)
         3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
         3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] ref_result(logic [1:0] src, logic [2:0] ac, logic [31:0] alu,
                                              logic [31:0] rdata, logic [31:0] pc4);
      if (src == 2'b01) return ref_load(rdata, alu[1:0], ac);
      if (src == 2'b10) return pc4;
      return alu;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_res = '0; m_retire = '0; m_stall = '0;
   endtask

   // Drives one M-stage slot, advances one clock, updates the model, then
   // returns 1 time unit after the edge so callers sample settled outputs.
   task automatic step(input logic st, input logic fl, input logic vm, input logic rwm,
                       input logic [1:0] src, input logic [2:0] ac, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4);
      bus.cache_stall = st;  bus.flush_w = fl;  bus.valid_m = vm;  bus.reg_write_m = rwm;
      bus.result_src_m = src; bus.addressing_control_m = ac; bus.rd_m = rd;
      bus.alu_result_m = alu; bus.read_data_m = rdata; bus.pc_plus4_m = pc4;
      @(posedge clk);
      if (st) begin
         m_stall = m_stall + 32'd1;
      end else begin
         m_valid = vm & ~fl;
         m_rw    = vm & rwm & (rd != 5'd0) & ~fl;
         m_rd    = fl ? 5'd0 : rd;
         m_res   = fl ? 32'd0 : ref_result(src, ac, alu, rdata, pc4);
         if (m_valid) m_retire = m_retire + 32'd1;
      end
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({bus.valid_w, bus.reg_write_w, bus.rd_w, bus.result_w} !== 39'd0) begin
         $display("FAIL reset_w: got v=%b rw=%b rd=%0d res=%h, need all 0",
                  bus.valid_w, bus.reg_write_w, bus.rd_w, bus.result_w);
      end else passes++;
      checks++;
      if (bus.retire_count !== 32'd0 || bus.stall_count !== 32'd0) begin
         $display("FAIL reset_cnt: got retire=%0d stall=%0d, need 0/0",
                  bus.retire_count, bus.stall_count);
      end else passes++;
      $display("reset: v=%b rw=%b rd=%0d res=%h retire=%0d stall=%0d", bus.valid_w,
               bus.reg_write_w, bus.rd_w, bus.result_w, bus.retire_count, bus.stall_count);
   endtask

   task automatic test_load_extend();
      logic [1:0]  offs [6];
      logic [2:0]  acs  [6];
      logic [31:0] exps [6];
      offs = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
      acs  = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      exps = '{32'h0000_0001, 32'hFFFF_FF80, 32'h0000_0080,
               32'hFFFF_80F1, 32'h0000_7F01, 32'h80F1_7F01};
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, acs[i], 5'd1, {30'h400, offs[i]}, 32'h80F1_7F01, 32'd0);
         checks++;
         if (bus.result_w !== exps[i]) begin
            $display("FAIL load_dir[%0d]: got %h, need %h", i, bus.result_w, exps[i]);
         end else passes++;
         $display("load ac=%b off=%0d -> %h", acs[i], offs[i], bus.result_w);
      end
      for (int i = 0; i < 24; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'($urandom), 5'($urandom), $urandom, $urandom, 32'd0);
         checks++;
         if (bus.result_w !== m_res || bus.rd_w !== m_rd || bus.reg_write_w !== m_rw) begin
            $display("FAIL load_rand[%0d]: got res=%h rd=%0d rw=%b, need res=%h rd=%0d rw=%b",
                     i, bus.result_w, bus.rd_w, bus.reg_write_w, m_res, m_rd, m_rw);
         end else passes++;
         $display("load_rand[%0d] res=%h", i, bus.result_w);
      end
   endtask

   task automatic test_result_select();
      logic [1:0]  srcs [3];
      logic [31:0] exps [3];
      srcs = '{2'b00, 2'b10, 2'b11};
      exps = '{32'h0000_0010, 32'h0000_0104, 32'h0000_0010};
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, srcs[i], 3'b010, 5'd3, 32'h10, 32'hDEAD_BEEF, 32'h104);
         checks++;
         if (bus.result_w !== exps[i] || bus.reg_write_w !== 1'b1) begin
            $display("FAIL result_sel[%0d]: got res=%h rw=%b, need res=%h rw=1",
                     i, bus.result_w, bus.reg_write_w, exps[i]);
         end else passes++;
         $display("result src=%b -> %h", srcs[i], bus.result_w);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b010, 5'd0, 32'h10, 32'd0, 32'h104);
      checks++;
      if (bus.reg_write_w !== 1'b0 || bus.valid_w !== 1'b1) begin
         $display("FAIL rd_zero: got rw=%b v=%b, need rw=0 v=1", bus.reg_write_w, bus.valid_w);
      end else passes++;
      $display("rd0 write: rw=%b", bus.reg_write_w);
   endtask

   task automatic test_stall_hold();
      logic [31:0] r0, s0;
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b010, 5'd5, 32'h1000, 32'hAAAA_5555, 32'd0);
      r0 = m_retire;
      s0 = m_stall;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b1, 2'($urandom), 3'($urandom), 5'd9, $urandom, $urandom, $urandom);
         checks++;
         if (bus.rd_w !== 5'd5 || bus.result_w !== 32'hAAAA_5555 || bus.valid_w !== 1'b1) begin
            $display("FAIL stall_hold[%0d]: got rd=%0d res=%h v=%b, need rd=5 res=aaaa5555 v=1",
                     i, bus.rd_w, bus.result_w, bus.valid_w);
         end else passes++;
         $display("stall[%0d] rd=%0d res=%h", i, bus.rd_w, bus.result_w);
      end
      checks++;
      if (bus.stall_count !== s0 + 32'd3 || bus.retire_count !== r0) begin
         $display("FAIL stall_cnt: got stall=%0d retire=%0d, need stall=%0d retire=%0d",
                  bus.stall_count, bus.retire_count, s0 + 32'd3, r0);
      end else passes++;
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b010, 5'd9, 32'h1234, 32'd0, 32'd0);
      checks++;
      if (bus.rd_w !== 5'd9 || bus.result_w !== 32'h1234 || bus.retire_count !== r0 + 32'd1) begin
         $display("FAIL stall_release: got rd=%0d res=%h retire=%0d, need rd=9 res=00001234 retire=%0d",
                  bus.rd_w, bus.result_w, bus.retire_count, r0 + 32'd1);
      end else passes++;
      $display("stall release rd=%0d res=%h", bus.rd_w, bus.result_w);
   endtask

   task automatic test_flush();
      logic [31:0] r0;
      r0 = m_retire;
      step(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 3'b010, 5'd7, 32'h55, 32'd0, 32'd0);
      checks++;
      if ({bus.valid_w, bus.reg_write_w, bus.rd_w, bus.result_w} !== 39'd0 || bus.retire_count !== r0) begin
         $display("FAIL flush_bubble: got v=%b rw=%b rd=%0d res=%h retire=%0d, need zeros retire=%0d",
                  bus.valid_w, bus.reg_write_w, bus.rd_w, bus.result_w, bus.retire_count, r0);
      end else passes++;
      $display("flush: v=%b rw=%b", bus.valid_w, bus.reg_write_w);
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b010, 5'd12, 32'h77, 32'd0, 32'd0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 3'b010, 5'd13, 32'h99, 32'd0, 32'd0);
      checks++;
      if (bus.valid_w !== 1'b1 || bus.rd_w !== 5'd12 || bus.result_w !== 32'h77) begin
         $display("FAIL flush_during_stall: got v=%b rd=%0d res=%h, need v=1 rd=12 res=00000077",
                  bus.valid_w, bus.rd_w, bus.result_w);
      end else passes++;
      $display("flush+stall: rd=%0d res=%h", bus.rd_w, bus.result_w);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
              1'($urandom), 2'($urandom), 3'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
         checks++;
         if ({bus.valid_w, bus.reg_write_w, bus.rd_w, bus.result_w, bus.retire_count, bus.stall_count}
             !== {m_valid, m_rw, m_rd, m_res, m_retire, m_stall}) begin
            $display("FAIL random[%0d]: got v=%b rw=%b rd=%0d res=%h ret=%0d stl=%0d, need v=%b rw=%b rd=%0d res=%h ret=%0d stl=%0d",
                     i, bus.valid_w, bus.reg_write_w, bus.rd_w, bus.result_w, bus.retire_count,
                     bus.stall_count, m_valid, m_rw, m_rd, m_res, m_retire, m_stall);
         end else passes++;
         $display("random[%0d] v=%b rd=%0d res=%h ret=%0d stl=%0d", i, bus.valid_w, bus.rd_w,
                  bus.result_w, bus.retire_count, bus.stall_count);
      end
   endtask

   task automatic test_async_reset();
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b010, 5'd4, 32'hCAFE, 32'd0, 32'd0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b010, 5'd6, 32'hBEEF, 32'd0, 32'd0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({bus.valid_w, bus.reg_write_w, bus.rd_w, bus.result_w, bus.retire_count, bus.stall_count} !== 103'd0) begin
         $display("FAIL async_reset_immediate: got v=%b rw=%b rd=%0d res=%h ret=%0d stl=%0d, need all 0",
                  bus.valid_w, bus.reg_write_w, bus.rd_w, bus.result_w, bus.retire_count, bus.stall_count);
      end else passes++;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.valid_w, bus.reg_write_w, bus.rd_w, bus.result_w, bus.retire_count, bus.stall_count} !== 103'd0) begin
         $display("FAIL async_reset_held: got v=%b res=%h ret=%0d stl=%0d, need all 0",
                  bus.valid_w, bus.result_w, bus.retire_count, bus.stall_count);
      end else passes++;
      $display("async reset: v=%b res=%h ret=%0d stl=%0d", bus.valid_w, bus.result_w,
               bus.retire_count, bus.stall_count);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b010, 5'd8, 32'h88, 32'd0, 32'd0);
      checks++;
      if (bus.valid_w !== 1'b0 || bus.result_w !== 32'd0 || bus.stall_count !== 32'd1) begin
         $display("FAIL post_reset_stall: got v=%b res=%h stl=%0d, need v=0 res=0 stl=1",
                  bus.valid_w, bus.result_w, bus.stall_count);
      end else passes++;
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b010, 5'd8, 32'h88, 32'd0, 32'd0);
      checks++;
      if (bus.rd_w !== 5'd8 || bus.result_w !== 32'h88 || bus.retire_count !== 32'd1) begin
         $display("FAIL post_reset_capture: got rd=%0d res=%h ret=%0d, need rd=8 res=00000088 ret=1",
                  bus.rd_w, bus.result_w, bus.retire_count);
      end else passes++;
      $display("post reset capture rd=%0d res=%h", bus.rd_w, bus.result_w);
   endtask

   task automatic test_counter_wrap();
      for (int i = 0; i < 16; i++) begin
         bus4.valid_m = 1'b1;
         bus4.reg_write_m = 1'b1;
         bus4.rd_m = 5'($urandom_range(1, 31));
         bus4.alu_result_m = $urandom;
         @(posedge clk);
         #1;
         checks++;
         if (bus4.retire_count !== 4'((i + 1) % 16) || bus4.stall_count !== 4'd0) begin
            $display("FAIL wrap[%0d]: got retire=%0d stall=%0d, need retire=%0d stall=0",
                     i, bus4.retire_count, bus4.stall_count, (i + 1) % 16);
         end else passes++;
         $display("wrap[%0d] retire=%0d", i, bus4.retire_count);
      end
      bus4.valid_m = 1'b0;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      rst_n  = 1'b0;
      model_reset();
      bus.cache_stall = 1'b0; bus.flush_w = 1'b0; bus.valid_m = 1'b0; bus.reg_write_m = 1'b0;
      bus.result_src_m = '0; bus.addressing_control_m = '0; bus.rd_m = '0;
      bus.alu_result_m = '0; bus.read_data_m = '0; bus.pc_plus4_m = '0;
      bus4.cache_stall = 1'b0; bus4.flush_w = 1'b0; bus4.valid_m = 1'b0; bus4.reg_write_m = 1'b0;
      bus4.result_src_m = '0; bus4.addressing_control_m = '0; bus4.rd_m = '0;
      bus4.alu_result_m = '0; bus4.read_data_m = '0; bus4.pc_plus4_m = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      test_load_extend();
      test_result_select();
      test_stall_hold();
      test_flush();
      test_random();
      test_async_reset();
      test_counter_wrap();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
